// File: rtl/ctr_hs.sv
//==============================================================================
// Module      : ctr_hs
// Description : One-hot control FSM for the alpacacorn accumulator CPU with a
//               req/ack memory handshake. Optional CTR_TIMEOUT_EN adds a
//               bus-timeout watchdog that traps into a sticky ERR state.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef ADR_WIDTH
`define ADR_WIDTH 6
`endif
`ifndef OP_WIDTH
`define OP_WIDTH 2
`define OP_NOR 2'd0
`define OP_ADD 2'd1
`define OP_STA 2'd2
`define OP_JCC 2'd3
`endif
`ifndef CTR_MARMUX_WIDTH
`define CTR_MARMUX_WIDTH 1
`define MAR_OP_PC  1'b0
`define MAR_OP_ARG 1'b1
`endif
`ifndef CTR_CARRYMUX_WIDTH
`define CTR_CARRYMUX_WIDTH 2
`define CARRY_OP_KEEP 2'd0
`define CARRY_OP_GEN  2'd1
`define CARRY_OP_CLR  2'd2
`endif

module ctr_hs #(
    parameter int ADR_WIDTH = `ADR_WIDTH,
    parameter int TIMEOUT   = 15
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           carry_i,
    input  logic [`OP_WIDTH-1:0]           op_i,
    input  logic                           mem_ack_i,
    output logic                           mem_req_o,
    output logic                           err_o,
    output logic [`CTR_MARMUX_WIDTH-1:0]   ctr_marmux_o,
    output logic [`CTR_CARRYMUX_WIDTH-1:0] ctr_carrymux_o,
    output logic [`OP_WIDTH-1:0]           ctr_aluop_o,
    output logic                           ctr_pc_reg_en_o,
    output logic                           ctr_a_reg_en_o,
    output logic                           ctr_mar_reg_en_o,
    output logic                           ctr_d_reg_en_o,
    output logic                           ctr_we_o
);

    if (ADR_WIDTH < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_cfg_bad
        $error("ctr_hs: ADR_WIDTH must be >= 1 and TIMEOUT within 1..255");
    end

    typedef enum logic [7:0] {
        S_LDPC   = 8'b0000_0001,
        S_FETCH  = 8'b0000_0010,
        S_DECODE = 8'b0000_0100,
        S_READ   = 8'b0000_1000,
        S_EXEC   = 8'b0001_0000,
        S_WRITE  = 8'b0010_0000,
        S_JUMP   = 8'b0100_0000,
        S_ERR    = 8'b1000_0000
    } state_t;

    state_t               state_q, state_d;
    logic [`OP_WIDTH-1:0] op_q, op_d;
    logic                 timeout;

`ifdef CTR_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // An ack in the same cycle as the limit wins over the timeout.
    always_comb begin
        timeout    = mem_req_o && !mem_ack_i && (wait_cnt_q == 8'(TIMEOUT));
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q || mem_ack_i) begin
            wait_cnt_d = 8'd0;
        end else if (mem_req_o) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_LDPC;
            op_q    <= `OP_ADD;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        mem_req_o        = 1'b0;
        err_o            = 1'b0;
        ctr_marmux_o     = `MAR_OP_PC;
        ctr_carrymux_o   = `CARRY_OP_KEEP;
        ctr_aluop_o      = `OP_ADD;
        ctr_pc_reg_en_o  = 1'b0;
        ctr_a_reg_en_o   = 1'b0;
        ctr_mar_reg_en_o = 1'b0;
        ctr_d_reg_en_o   = 1'b0;
        ctr_we_o         = 1'b0;

        unique case (state_q)
            S_LDPC: begin
                ctr_mar_reg_en_o = 1'b1;
                state_d          = S_FETCH;
            end
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    ctr_d_reg_en_o  = 1'b1;
                    ctr_pc_reg_en_o = 1'b1;
                    state_d         = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                ctr_marmux_o     = `MAR_OP_ARG;
                ctr_mar_reg_en_o = 1'b1;
                op_d             = op_i;
                case (op_i)
                    `OP_STA: state_d = S_WRITE;
                    `OP_JCC: state_d = carry_i ? S_JUMP : S_LDPC;
                    default: state_d = S_READ;
                endcase
            end
            S_READ: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    ctr_d_reg_en_o = 1'b1;
                    state_d        = S_EXEC;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_EXEC: begin
                ctr_a_reg_en_o = 1'b1;
                ctr_carrymux_o = `CARRY_OP_GEN;
                ctr_aluop_o    = op_q;
                state_d        = S_LDPC;
            end
            S_WRITE: begin
                mem_req_o = 1'b1;
                ctr_we_o  = 1'b1;
                if (mem_ack_i) begin
                    state_d = S_LDPC;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_JUMP: begin
                ctr_carrymux_o = `CARRY_OP_CLR;
                state_d        = S_LDPC;
            end
            S_ERR: begin
`ifdef CTR_TIMEOUT_EN
                err_o = 1'b1;
`endif
            end
            default: state_d = S_LDPC;
        endcase
    end

endmodule

`default_nettype wire
